// File: rtl/demux_reg_pkg.sv
// ============================================================================
// Module      : demux_reg_pkg
// Description : Shared mode encodings for the demux capture register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_reg_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_ADDR  = 2'b01;
  localparam logic [1:0] MODE_AUTO  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

endpackage : demux_reg_pkg

`default_nettype wire

// File: rtl/demux_lane_dff.sv
// ============================================================================
// Module      : demux_lane_dff
// Description : Single lane flop with async reset/preset (both low = hold),
//               synchronous clear and load enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_lane_dff (
  input  logic clk,
  input  logic rstn,
  input  logic pstn,
  input  logic en,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic r_q;

  // Simultaneous reset and preset freeze the flop rather than picking a winner.
  always_ff @(posedge clk or negedge rstn or negedge pstn) begin
    if (!rstn && !pstn) begin
      r_q <= r_q;
    end else if (!rstn) begin
      r_q <= 1'b0;
    end else if (!pstn) begin
      r_q <= 1'b1;
    end else if (clr) begin
      r_q <= 1'b0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : demux_lane_dff

`default_nettype wire

// File: rtl/demux_capture_reg.sv
// ============================================================================
// Module      : demux_capture_reg
// Description : 1-to-N demultiplexing capture register with addressed and
//               auto-advancing lane steering, written-lane tracking and a
//               frame-complete pulse. Optional even-parity output enabled by
//               defining DEMUX_REG_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_capture_reg
  import demux_reg_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            pstn,
  input  logic            d,
  input  logic [SELW-1:0] sel,
  input  logic [1:0]      mode,
  output logic [N-1:0]    q,
  output logic [SELW-1:0] ptr,
  output logic            full,
  output logic            done
`ifdef DEMUX_REG_PARITY_EN
  ,
  output logic            par
`endif
);

  localparam logic [SELW-1:0] C_LAST_LANE = SELW'(N - 1);

  logic [N-1:0]    w_lane_en;
  logic [N-1:0]    w_mask;
  logic            w_clr;
  logic            w_auto;
  logic [SELW-1:0] r_ptr;
  logic            r_done;

  assign w_clr  = (mode == MODE_CLEAR);
  assign w_auto = (mode == MODE_AUTO);

  // Out-of-range selects match no lane, so they write nothing.
  always_comb begin
    w_lane_en = '0;
    for (int i = 0; i < N; i++) begin
      if (mode == MODE_ADDR) begin
        w_lane_en[i] = (sel == SELW'(i));
      end else if (w_auto) begin
        w_lane_en[i] = (r_ptr == SELW'(i));
      end
    end
  end

  generate
    for (genvar g = 0; g < N; g++) begin : g_lane
      demux_lane_dff u_data (
        .clk  (clk),
        .rstn (rstn),
        .pstn (pstn),
        .en   (w_lane_en[g]),
        .clr  (w_clr),
        .d    (d),
        .q    (q[g])
      );

      // The written mask is a lane flop that always loads 1.
      demux_lane_dff u_mask (
        .clk  (clk),
        .rstn (rstn),
        .pstn (pstn),
        .en   (w_lane_en[g]),
        .clr  (w_clr),
        .d    (1'b1),
        .q    (w_mask[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn or negedge pstn) begin
    if (!rstn && !pstn) begin
      r_ptr  <= r_ptr;
      r_done <= r_done;
    end else if (!rstn || !pstn) begin
      r_ptr  <= '0;
      r_done <= 1'b0;
    end else if (w_clr) begin
      r_ptr  <= '0;
      r_done <= 1'b0;
    end else if (w_auto) begin
      if (r_ptr == C_LAST_LANE) begin
        r_ptr  <= '0;
        r_done <= 1'b1;
      end else begin
        r_ptr  <= r_ptr + SELW'(1);
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign ptr  = r_ptr;
  assign done = r_done;
  assign full = &w_mask;

`ifdef DEMUX_REG_PARITY_EN
  logic [N-1:0] w_q_next;
  logic         r_par;

  // Parity is taken from the next lane value so it lands on the same edge as q.
  always_comb begin
    w_q_next = q;
    for (int i = 0; i < N; i++) begin
      if (w_clr) begin
        w_q_next[i] = 1'b0;
      end else if (w_lane_en[i]) begin
        w_q_next[i] = d;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn or negedge pstn) begin
    if (!rstn && !pstn) begin
      r_par <= r_par;
    end else if (!rstn) begin
      r_par <= 1'b0;
    end else if (!pstn) begin
      r_par <= ^{N{1'b1}};
    end else begin
      r_par <= ^w_q_next;
    end
  end

  assign par = r_par;
`endif

endmodule : demux_capture_reg

`default_nettype wire

// File: tb/tb_demux_capture_reg.sv
// ============================================================================
// Module      : tb_demux_capture_reg
// Description : Scoreboard testbench for demux_capture_reg (N=4, SELW=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_capture_reg;

  localparam int N    = 4;
  localparam int SELW = 2;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_ADDR  = 2'b01;
  localparam logic [1:0] M_AUTO  = 2'b10;
  localparam logic [1:0] M_CLEAR = 2'b11;

  logic            clk;
  logic            rstn;
  logic            pstn;
  logic            d;
  logic [SELW-1:0] sel;
  logic [1:0]      mode;
  logic [N-1:0]    q;
  logic [SELW-1:0] ptr;
  logic            full;
  logic            done;
`ifdef DEMUX_REG_PARITY_EN
  logic            par;
`endif

  demux_capture_reg #(.N(N), .SELW(SELW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .pstn (pstn),
    .d    (d),
    .sel  (sel),
    .mode (mode),
    .q    (q),
    .ptr  (ptr),
    .full (full),
    .done (done)
`ifdef DEMUX_REG_PARITY_EN
    ,
    .par  (par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [N-1:0]    q;
    logic [SELW-1:0] ptr;
    logic            full;
    logic            done;
    logic            par;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  // Expected parity is supplied by hand in each vector.
  task automatic expect_state(input string nm, input logic [N-1:0] eq,
                              input logic [SELW-1:0] ep, input logic ef,
                              input logic ed, input logic epar);
    exp_t e;
    e.name = nm; e.q = eq; e.ptr = ep; e.full = ef; e.done = ed; e.par = epar;
    sb.push_back(e);
    -> chk_ev;
  endtask

  task automatic step(input logic [1:0] m, input logic [SELW-1:0] s, input logic dd);
    @(negedge clk);
    mode = m; sel = s; d = dd;
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(chk_ev);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        ok = (q === e.q) && (ptr === e.ptr) && (full === e.full) && (done === e.done);
`ifdef DEMUX_REG_PARITY_EN
        ok = ok && (par === e.par);
`endif
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL %s: got q=%b ptr=%0d full=%b done=%b, expected q=%b ptr=%0d full=%b done=%b par=%b",
                   e.name, q, ptr, full, done, e.q, e.ptr, e.full, e.done, e.par);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; pstn = 1'b1; d = 1'b0; sel = '0; mode = M_HOLD;
    #1;
    expect_state("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    #2 rstn = 1'b1;

    // Async preset held for one cycle
    @(negedge clk); pstn = 1'b0;
    #1 expect_state("preset_async", 4'b1111, 2'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); pstn = 1'b1;
    #1 expect_state("preset_release", 4'b1111, 2'd0, 1'b1, 1'b0, 1'b0);

    step(M_CLEAR, 2'd0, 1'b1); expect_state("clear1", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(M_ADDR,  2'd2, 1'b1); expect_state("addr_sel2", 4'b0100, 2'd0, 1'b0, 1'b0, 1'b1);
    step(M_HOLD,  2'd1, 1'b1); expect_state("hold", 4'b0100, 2'd0, 1'b0, 1'b0, 1'b1);

    // AUTO frame 1,0,1,1
    step(M_CLEAR, 2'd0, 1'b0); expect_state("clear2", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(M_AUTO, 2'd3, 1'b1); expect_state("auto_a0", 4'b0001, 2'd1, 1'b0, 1'b0, 1'b1);
    step(M_AUTO, 2'd3, 1'b0); expect_state("auto_a1", 4'b0001, 2'd2, 1'b0, 1'b0, 1'b1);
    step(M_AUTO, 2'd3, 1'b1); expect_state("auto_a2", 4'b0101, 2'd3, 1'b0, 1'b0, 1'b0);
    step(M_AUTO, 2'd3, 1'b1); expect_state("auto_a3_done", 4'b1101, 2'd0, 1'b1, 1'b1, 1'b1);
    step(M_HOLD, 2'd0, 1'b0); expect_state("done_pulse_end", 4'b1101, 2'd0, 1'b1, 1'b0, 1'b1);

    // AUTO frame 1,1,1,0 (parity 1,0,1,1)
    step(M_CLEAR, 2'd0, 1'b0); expect_state("clear3", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(M_AUTO, 2'd0, 1'b1); expect_state("auto_b0", 4'b0001, 2'd1, 1'b0, 1'b0, 1'b1);
    step(M_AUTO, 2'd0, 1'b1); expect_state("auto_b1", 4'b0011, 2'd2, 1'b0, 1'b0, 1'b0);
    step(M_AUTO, 2'd0, 1'b1); expect_state("auto_b2", 4'b0111, 2'd3, 1'b0, 1'b0, 1'b1);
    step(M_AUTO, 2'd0, 1'b0); expect_state("auto_b3_done", 4'b0111, 2'd0, 1'b1, 1'b1, 1'b1);
    @(negedge clk); mode = M_HOLD; pstn = 1'b0;
    #1 expect_state("preset_par", 4'b1111, 2'd0, 1'b1, 1'b0, 1'b0);
    #1 pstn = 1'b1;
    step(M_AUTO, 2'd0, 1'b0); expect_state("auto_after_preset", 4'b1110, 2'd1, 1'b1, 1'b0, 1'b1);

    // Mid-frame async reset aborts the frame
    step(M_CLEAR, 2'd0, 1'b0); expect_state("clear4", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(M_AUTO, 2'd0, 1'b1); expect_state("auto_c0", 4'b0001, 2'd1, 1'b0, 1'b0, 1'b1);
    step(M_AUTO, 2'd0, 1'b1); expect_state("auto_c1", 4'b0011, 2'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk); mode = M_HOLD; rstn = 1'b0;
    #1 expect_state("midframe_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    #1 rstn = 1'b1;
    step(M_AUTO, 2'd0, 1'b1); expect_state("auto_restart_lane0", 4'b0001, 2'd1, 1'b0, 1'b0, 1'b1);
    step(M_ADDR, 2'd1, 1'b0); expect_state("addr_sel1", 4'b0001, 2'd1, 1'b0, 1'b0, 1'b1);
    step(M_ADDR, 2'd2, 1'b1); expect_state("addr_sel2b", 4'b0101, 2'd1, 1'b0, 1'b0, 1'b0);
    step(M_ADDR, 2'd3, 1'b0); expect_state("addr_full", 4'b0101, 2'd1, 1'b1, 1'b0, 1'b0);

    // Reset and preset together hold state, even across a clock edge
    step(M_CLEAR, 2'd0, 1'b0); expect_state("clear5", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(M_ADDR, 2'd1, 1'b1); expect_state("addr_1010_a", 4'b0010, 2'd0, 1'b0, 1'b0, 1'b1);
    step(M_ADDR, 2'd3, 1'b1); expect_state("addr_1010_b", 4'b1010, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); mode = M_AUTO; d = 1'b1; rstn = 1'b0; pstn = 1'b0;
    #1 expect_state("both_low_hold", 4'b1010, 2'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    expect_state("both_low_clocked", 4'b1010, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); mode = M_HOLD; rstn = 1'b1; pstn = 1'b1;
    step(M_CLEAR, 2'd0, 1'b0); expect_state("clear_final", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_demux_capture_reg

`default_nettype wire
